multi_line_buffers: RTL and testbench

MULTI_LINE_BUFFERS -- requirements
Module: multi_line_buffers

---
 rtl/multi_line_buffers.sv | 213 +++++++++++++++++++++
 tb/tb_multi_line_buffers.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/multi_line_buffers.sv
// Multi line-buffer display cache: a round-robin fill engine copies frame-buffer rows
// into per-line RAMs while the display side reads the currently selected buffer.
module multi_line_buffers #(
    parameter int COLR_PXL_WIDTH   = 12,
    parameter int WIDTH_PX         = 640,
    parameter int TILE_WIDTH       = 4,
    parameter int TILES_PER_ROW    = 5,
    parameter int FBUFF_ADDR_WIDTH = 12,
    parameter int FBUFF_DEPTH      = 3840,
    parameter int NUM_BUFFS        = 2,
    parameter int FBUFF_RD_LAT     = 1,
    localparam int TILES_PER_LINE   = WIDTH_PX / TILE_WIDTH,
    localparam int ROWS_PER_LINE    = TILES_PER_LINE / TILES_PER_ROW,
    localparam int FBUFF_DATA_WIDTH = TILES_PER_ROW * COLR_PXL_WIDTH,
    localparam int PXL_ID_W         = $clog2(TILES_PER_LINE)
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic [NUM_BUFFS-1:0]        buff_fill_req_i,
    input  logic [NUM_BUFFS-1:0]        buff_sel_i,
    input  logic [PXL_ID_W-1:0]         disp_pxl_id_i,
    output logic [COLR_PXL_WIDTH-1:0]   disp_pxl_o,
    input  logic                        fbuff_addr_rst_i,
    input  logic [FBUFF_DATA_WIDTH-1:0] fbuff_data_i,
    output logic [FBUFF_ADDR_WIDTH-1:0] fbuff_addr_o,
    output logic                        fbuff_en_o,
    output logic [NUM_BUFFS-1:0]        buff_fill_done_o,
    output logic [NUM_BUFFS-1:0]        buff_busy_o,
    output logic                        conflict_o
);

    localparam int SEL_W  = $clog2(NUM_BUFFS);
    localparam int ROW_W  = (ROWS_PER_LINE > 1) ? $clog2(ROWS_PER_LINE) : 1;
    localparam int TILE_W = (TILES_PER_ROW > 1) ? $clog2(TILES_PER_ROW) : 1;
    localparam int WAIT_W = (FBUFF_RD_LAT > 1) ? $clog2(FBUFF_RD_LAT) : 1;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_READ  = 3'd1;
    localparam logic [2:0] S_WAIT  = 3'd2;
    localparam logic [2:0] S_WRITE = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    logic [2:0]                  r_state;
    logic [NUM_BUFFS-1:0]        r_pending;
    logic [SEL_W-1:0]            r_last;
    logic [SEL_W-1:0]            r_sel;
    logic [ROW_W-1:0]            r_row;
    logic [TILE_W-1:0]           r_tile;
    logic [WAIT_W-1:0]           r_wait;
    logic [FBUFF_DATA_WIDTH-1:0] r_data;
    logic [FBUFF_ADDR_WIDTH-1:0] r_addr;
    logic                        r_addr_rst_pend;
    logic                        r_conflict;
    logic                        r_disp_valid;
    logic [SEL_W-1:0]            r_disp_idx;

    logic                        w_rr_hit;
    logic [SEL_W-1:0]            w_rr_idx;
    logic [SEL_W-1:0]            w_rr_try;
    logic                        w_disp_hit;
    logic [SEL_W-1:0]            w_disp_idx;
    logic [NUM_BUFFS-1:0]        w_fill_oh;
    logic [NUM_BUFFS-1:0]        w_launch_oh;
    logic                        w_in_write;
    logic                        w_wr_blocked;
    logic [PXL_ID_W-1:0]         w_wr_addr;
    logic [COLR_PXL_WIDTH-1:0]   w_wr_data;
    logic [NUM_BUFFS-1:0][COLR_PXL_WIDTH-1:0] w_ram_q;

    // Round-robin search: smallest offset after the last-served index wins.
    always_comb begin
        w_rr_hit = 1'b0;
        w_rr_idx = '0;
        w_rr_try = '0;
        for (int off = NUM_BUFFS; off >= 1; off--) begin
            w_rr_try = SEL_W'((int'(r_last) + off) % NUM_BUFFS);
            if (r_pending[w_rr_try]) begin
                w_rr_hit = 1'b1;
                w_rr_idx = w_rr_try;
            end
        end
    end

    always_comb begin
        w_disp_hit = 1'b0;
        w_disp_idx = '0;
        for (int i = NUM_BUFFS - 1; i >= 0; i--) begin
            if (buff_sel_i[i]) begin
                w_disp_hit = 1'b1;
                w_disp_idx = SEL_W'(i);
            end
        end
    end

    assign w_fill_oh    = (r_state != S_IDLE) ? (NUM_BUFFS'(1) << r_sel) : '0;
    assign w_launch_oh  = (r_state == S_IDLE && w_rr_hit) ? (NUM_BUFFS'(1) << w_rr_idx) : '0;
    assign w_in_write   = (r_state == S_WRITE);
    assign w_wr_blocked = w_in_write && w_disp_hit && (w_disp_idx == r_sel);
    assign w_wr_addr    = PXL_ID_W'(int'(r_row) * TILES_PER_ROW + int'(r_tile));
    assign w_wr_data    = r_data[int'(r_tile) * COLR_PXL_WIDTH +: COLR_PXL_WIDTH];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state         <= S_IDLE;
            r_pending       <= '0;
            r_last          <= SEL_W'(NUM_BUFFS - 1);
            r_sel           <= '0;
            r_row           <= '0;
            r_tile          <= '0;
            r_wait          <= '0;
            r_data          <= '0;
            r_addr          <= '0;
            r_addr_rst_pend <= 1'b0;
            r_conflict      <= 1'b0;
            r_disp_valid    <= 1'b0;
            r_disp_idx      <= '0;
        end else begin
            // Requests for a buffer already pending or being filled merge into it.
            r_pending    <= (r_pending & ~w_launch_oh) | (buff_fill_req_i & ~w_fill_oh & ~w_launch_oh);
            r_disp_valid <= w_disp_hit;
            r_disp_idx   <= w_disp_idx;
            if (w_wr_blocked) begin
                r_conflict <= 1'b1;
            end
            if (fbuff_addr_rst_i && r_state != S_IDLE && r_state != S_DONE) begin
                r_addr_rst_pend <= 1'b1;
            end
            case (r_state)
                S_IDLE: begin
                    if (fbuff_addr_rst_i) begin
                        r_addr <= '0;
                    end
                    if (w_rr_hit) begin
                        r_sel   <= w_rr_idx;
                        r_last  <= w_rr_idx;
                        r_row   <= '0;
                        r_tile  <= '0;
                        r_state <= S_READ;
                    end
                end
                S_READ: begin
                    r_wait  <= '0;
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    if (r_wait == WAIT_W'(FBUFF_RD_LAT - 1)) begin
                        r_data  <= fbuff_data_i;
                        r_addr  <= (r_addr == FBUFF_ADDR_WIDTH'(FBUFF_DEPTH - 1)) ? '0 : r_addr + 1'b1;
                        r_tile  <= '0;
                        r_state <= S_WRITE;
                    end else begin
                        r_wait <= r_wait + 1'b1;
                    end
                end
                S_WRITE: begin
                    if (r_tile == TILE_W'(TILES_PER_ROW - 1)) begin
                        r_tile <= '0;
                        if (r_row == ROW_W'(ROWS_PER_LINE - 1)) begin
                            r_state <= S_DONE;
                        end else begin
                            r_row   <= r_row + 1'b1;
                            r_state <= S_READ;
                        end
                    end else begin
                        r_tile <= r_tile + 1'b1;
                    end
                end
                S_DONE: begin
                    // A frame-start rewind seen during the fill takes effect only now.
                    if (r_addr_rst_pend || fbuff_addr_rst_i) begin
                        r_addr <= '0;
                    end
                    r_addr_rst_pend <= 1'b0;
                    r_state         <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_BUFFS; gi++) begin : g_buf
            logic [COLR_PXL_WIDTH-1:0] r_mem [0:TILES_PER_LINE-1];
            logic [COLR_PXL_WIDTH-1:0] r_q;
            logic                      w_rd_sel;
            logic                      w_we;
            logic [PXL_ID_W-1:0]       w_addr;

            // The display owns the single port of the selected buffer.
            assign w_rd_sel = w_disp_hit && (w_disp_idx == SEL_W'(gi));
            assign w_we     = w_in_write && (r_sel == SEL_W'(gi)) && !w_rd_sel;
            assign w_addr   = w_rd_sel ? disp_pxl_id_i : w_wr_addr;

            always_ff @(posedge clk_i) begin
                if (w_we) begin
                    r_mem[w_addr] <= w_wr_data;
                end
                r_q <= r_mem[w_addr];
            end

            assign w_ram_q[gi] = r_q;
        end
    endgenerate

    assign disp_pxl_o       = r_disp_valid ? w_ram_q[r_disp_idx] : '0;
    assign fbuff_addr_o     = r_addr;
    assign fbuff_en_o       = (r_state == S_READ);
    assign buff_fill_done_o = (r_state == S_DONE) ? (NUM_BUFFS'(1) << r_sel) : '0;
    assign buff_busy_o      = r_pending | w_fill_oh;
    assign conflict_o       = r_conflict;

endmodule

// File: tb/tb_multi_line_buffers.sv
// Directed bench for multi_line_buffers: a default instance (read latency 1) and a
// second instance with read latency 3 and a 33-row frame buffer to exercise address wrap.
module tb_multi_line_buffers;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    // Default instance
    logic        m_rst = 1'b1;
    logic [1:0]  m_req = '0, m_sel = '0;
    logic [7:0]  m_id = '0;
    logic        m_arst = 1'b0;
    logic [59:0] m_fb;
    logic [11:0] m_pxl, m_addr;
    logic        m_en, m_conf;
    logic [1:0]  m_done, m_busy;

    // Latency-3, depth-33 instance
    logic        d_rst = 1'b1;
    logic [1:0]  d_req = '0, d_sel = '0;
    logic [7:0]  d_id = '0;
    logic        d_arst = 1'b0;
    logic [59:0] d_p1, d_p2, d_p3;
    logic [11:0] d_pxl, d_addr;
    logic        d_en, d_conf;
    logic [1:0]  d_done, d_busy;

    multi_line_buffers u_dut (
        .clk_i(clk), .rst_i(m_rst), .buff_fill_req_i(m_req), .buff_sel_i(m_sel),
        .disp_pxl_id_i(m_id), .disp_pxl_o(m_pxl), .fbuff_addr_rst_i(m_arst),
        .fbuff_data_i(m_fb), .fbuff_addr_o(m_addr), .fbuff_en_o(m_en),
        .buff_fill_done_o(m_done), .buff_busy_o(m_busy), .conflict_o(m_conf)
    );

    multi_line_buffers #(.FBUFF_RD_LAT(3), .FBUFF_DEPTH(33)) u_dut3 (
        .clk_i(clk), .rst_i(d_rst), .buff_fill_req_i(d_req), .buff_sel_i(d_sel),
        .disp_pxl_id_i(d_id), .disp_pxl_o(d_pxl), .fbuff_addr_rst_i(d_arst),
        .fbuff_data_i(d_p3), .fbuff_addr_o(d_addr), .fbuff_en_o(d_en),
        .buff_fill_done_o(d_done), .buff_busy_o(d_busy), .conflict_o(d_conf)
    );

    // Frame-buffer row n holds tiles n*5 .. n*5+4, tile k in bits [k*12 +: 12]
    function automatic logic [59:0] row_data(input int n);
        logic [59:0] r;
        r = '0;
        for (int k = 0; k < 5; k++) r[k*12 +: 12] = 12'(n * 5 + k);
        return r;
    endfunction

    always @(posedge clk) begin
        m_fb <= m_en ? row_data(int'(m_addr)) : '0;
        d_p1 <= d_en ? row_data(int'(d_addr)) : '0;
        d_p2 <= d_p1;
        d_p3 <= d_p2;
    end

    int n_chk = 0, n_pass = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Pulse a request on the default instance and wait for its done pulse.
    task automatic fill_main(input logic [1:0] mask, input int pulse_at,
                             output int len, output int addr_done, output int first_addr);
        int t0;
        bit seen;
        t0 = -1; seen = 0; len = -1; addr_done = -1; first_addr = -1;
        m_req = mask;
        tick();
        m_req = '0;
        for (int n = 0; n < 400 && !seen; n++) begin
            if (n == pulse_at) begin
                m_arst = 1'b1;
                m_req  = mask;
            end
            tick();
            m_arst = 1'b0;
            m_req  = '0;
            if (m_en && t0 < 0) begin
                t0 = n;
                first_addr = int'(m_addr);
            end
            if ((m_done & mask) != 0) begin
                seen = 1;
                len = n - t0 + 1;
                addr_done = int'(m_addr);
            end
        end
        if (!seen) chk("fill_timeout", 0, 1);
    endtask

    typedef struct {
        int         which;
        logic [1:0] sel;
        int         id;
        int         exp;
    } vec_t;

    vec_t vecs[13];

    initial begin
        int m_t0, m_t1, m_t2, m_en_cnt, m_d0_cnt, m_d1_cnt, m_busy_lo, m_a1, m_a2;
        int d_t0, d_t1, d_t2, d_en_cnt, d_last, d_bad_gap;
        int d_addrs[64];
        int len, ad, fa, act, cnt;

        vecs[0]  = '{0, 2'b01,   0,   0};
        vecs[1]  = '{0, 2'b01, 159, 159};
        vecs[2]  = '{0, 2'b10,   5, 165};
        vecs[3]  = '{0, 2'b11,   7,   7};
        vecs[4]  = '{0, 2'b00,   3,   0};
        vecs[5]  = '{0, 2'b10, 159, 319};
        vecs[6]  = '{0, 2'b01,  77,  77};
        vecs[7]  = '{1, 2'b01, 100, 100};
        vecs[8]  = '{1, 2'b10,   0, 160};
        vecs[9]  = '{1, 2'b10,   4, 164};
        vecs[10] = '{1, 2'b10,   5,   0};
        vecs[11] = '{1, 2'b10, 159, 154};
        vecs[12] = '{1, 2'b10,  12,   7};

        repeat (3) tick();
        m_rst = 1'b0;
        d_rst = 1'b0;
        tick();
        chk("rst_busy", int'(m_busy), 0);
        chk("rst_done", int'(m_done), 0);
        chk("rst_en", int'(m_en), 0);
        chk("rst_addr", int'(m_addr), 0);
        chk("rst_pxl", int'(m_pxl), 0);
        chk("rst_conflict", int'(m_conf), 0);

        // Both buffers requested together on both instances
        m_t0 = -1; m_t1 = -1; m_t2 = -1; m_en_cnt = 0; m_d0_cnt = 0; m_d1_cnt = 0;
        m_busy_lo = 0; m_a1 = -1; m_a2 = -1;
        d_t0 = -1; d_t1 = -1; d_t2 = -1; d_en_cnt = 0; d_last = 0; d_bad_gap = 0;
        m_req = 2'b11; d_req = 2'b11;
        tick();
        m_req = '0; d_req = '0;
        for (int n = 0; n < 1500; n++) begin
            if (m_t2 >= 0 && d_t2 >= 0) break;
            if (m_t2 < 0 && !m_busy[1]) m_busy_lo++;
            tick();
            if (m_en) begin
                if (m_en_cnt == 0) m_t0 = n;
                m_en_cnt++;
            end
            if (m_done[0]) begin m_d0_cnt++; m_t1 = n; m_a1 = int'(m_addr); end
            if (m_done[1]) begin m_d1_cnt++; m_t2 = n; m_a2 = int'(m_addr); end
            if (d_en) begin
                if (d_en_cnt == 0) d_t0 = n;
                else if (d_en_cnt != 32 && n - d_last != 9) d_bad_gap++;
                if (d_en_cnt < 64) d_addrs[d_en_cnt] = int'(d_addr);
                d_en_cnt++;
                d_last = n;
            end
            if (d_done[0]) d_t1 = n;
            if (d_done[1]) d_t2 = n;
        end
        if (m_t2 < 0 || d_t2 < 0) chk("dual_fill_timeout", 0, 1);
        repeat (5) begin
            tick();
            if (m_done[0]) m_d0_cnt++;
            if (m_done[1]) m_d1_cnt++;
        end
        chk("fill0_len", m_t1 - m_t0 + 1, 225);
        chk("fill0_addr", m_a1, 32);
        chk("fill1_gap", m_t2 - m_t1, 226);
        chk("fill1_addr", m_a2, 64);
        chk("en_pulses", m_en_cnt, 64);
        chk("done0_pulses", m_d0_cnt, 1);
        chk("done1_pulses", m_d1_cnt, 1);
        chk("busy1_low_cycles", m_busy_lo, 0);
        chk("lat3_fill_len", d_t1 - d_t0 + 1, 289);
        chk("lat3_en_gap_bad", d_bad_gap, 0);
        chk("lat3_fill1_gap", d_t2 - d_t1, 290);
        chk("wrap_read_a", d_addrs[32], 32);
        chk("wrap_read_b", d_addrs[33], 0);

        // Display read vectors
        for (int i = 0; i < 13; i++) begin
            if (vecs[i].which == 0) begin
                m_sel = vecs[i].sel; m_id = 8'(vecs[i].id);
            end else begin
                d_sel = vecs[i].sel; d_id = 8'(vecs[i].id);
            end
            tick();
            act = (vecs[i].which == 0) ? int'(m_pxl) : int'(d_pxl);
            chk($sformatf("disp_vec%0d", i), act, vecs[i].exp);
        end
        m_sel = '0; d_sel = '0;

        // Rewind and duplicate request in the middle of a fill
        fill_main(2'b01, 40, len, ad, fa);
        chk("rw_fill_len", len, 225);
        chk("rw_first_addr", fa, 64);
        chk("rw_addr_at_done", ad, 96);
        tick();
        chk("rw_addr_after_done", int'(m_addr), 0);
        chk("merge_busy", int'(m_busy), 0);
        cnt = 0;
        repeat (10) begin tick(); if (m_en) cnt++; end
        chk("merge_no_refill", cnt, 0);
        fill_main(2'b10, -1, len, ad, fa);
        chk("rw_next_first_addr", fa, 0);
        chk("rw_next_len", len, 225);
        chk("no_conflict_yet", int'(m_conf), 0);

        // Fill while the same buffer is on display
        m_sel = 2'b01;
        fill_main(2'b01, -1, len, ad, fa);
        chk("conflict_set", int'(m_conf), 1);
        m_sel = 2'b00;
        tick();
        chk("conflict_sticky", int'(m_conf), 1);
        chk("sel_none_pxl", int'(m_pxl), 0);
        m_sel = 2'b01; m_id = 8'd3;
        tick();
        chk("dropped_write_keeps", int'(m_pxl), 323);

        // Reset in the middle of a WRITE phase
        m_id = 8'd5;
        tick();
        chk("pre_rst_pxl", int'(m_pxl), 325);
        m_req = 2'b10;
        tick();
        m_req = '0;
        cnt = 0;
        for (int n = 0; n < 20 && !m_en; n++) tick();
        if (!m_en) chk("rst_test_no_read", 0, 1);
        tick();
        tick();
        m_rst = 1'b1;
        #1;
        chk("midrst_busy", int'(m_busy), 0);
        chk("midrst_done", int'(m_done), 0);
        chk("midrst_en", int'(m_en), 0);
        chk("midrst_addr", int'(m_addr), 0);
        chk("midrst_pxl", int'(m_pxl), 0);
        chk("midrst_conflict", int'(m_conf), 0);
        tick();
        tick();
        m_rst = 1'b0;
        m_sel = 2'b00;
        repeat (20) begin tick(); if (m_done != 0 || m_busy != 0) cnt++; end
        chk("post_rst_idle", cnt, 0);
        fill_main(2'b01, -1, len, ad, fa);
        chk("post_rst_len", len, 225);
        chk("post_rst_first_addr", fa, 0);
        chk("post_rst_addr", ad, 32);
        m_sel = 2'b01; m_id = 8'd100;
        tick();
        chk("post_rst_pxl", int'(m_pxl), 100);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
